// File: rtl/piso_ctrl_pkg.sv
// Shared definitions for the PISO frame sequencer and the PISO wrapper.
//   state_t     : sequencer states
//   PISO_WIDTH  : default serializer word width
//   min1_clog2  : register width able to hold 0..n-1, never below 1 bit
package piso_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int unsigned PISO_WIDTH = 10;

  // Width for a counter holding 0..n-1; a zero-width counter is not legal.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_gap_timer.sv
// Down-counter for the inter-frame idle gap.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (takes priority over dec)
//   load_val   : start value
//   dec        : decrement, holding at zero
//   zero_c     : counter is zero
module piso_gap_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] g_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q <= '0;
    end else if (load) begin
      g_q <= load_val;
    end else if (dec && (g_q != '0)) begin
      g_q <= g_q - W'(1);
    end
  end

  assign zero_c = (g_q == '0);

endmodule

// File: rtl/piso_frame_ctrl.sv
// Sequencer for a parallel-in/serial-out shift register without clock enable.
// Accepts words over valid/ready, drives the PISO LOAD/PI/SI, qualifies the
// serial output with valid/first/last, enforces an idle gap between frames
// and counts completed frames.
//   CLK, ASYNCRESETN     : clock, async active-low reset
//   IN_VALID/IN_DATA     : upstream word, MSB first on the serial line
//   IN_READY             : word accepted this cycle when IN_VALID is also high
//   HALT                 : blocks new loads, running frame completes
//   LOAD, PI, SI         : PISO controls
//   SO_VALID/FIRST/LAST  : PISO output carries a frame bit / its MSB / its LSB
//   BUSY                 : not idle
//   FRAMES               : completed frames, wraps
module piso_frame_ctrl
  import piso_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = PISO_WIDTH,
  parameter int unsigned GAP   = 0,
  parameter logic        FILL  = 1'b0,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             IN_READY,
  input  logic             HALT,
  output logic             LOAD,
  output logic [WIDTH-1:0] PI,
  output logic             SI,
  output logic             SO_VALID,
  output logic             SO_FIRST,
  output logic             SO_LAST,
  output logic             BUSY,
  output logic [CNT_W-1:0] FRAMES
);

  localparam int unsigned    IDX_W    = min1_clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam bit             B2B      = (GAP == 0);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic             ready_c;
  logic             load_c;
  logic             last_bit_c;
  logic             gap_zero_c;

  // Gap timer only exists when an idle gap is enforced.
  if (GAP > 0) begin : g_gap
    localparam int unsigned G_W = min1_clog2(GAP + 1);
    piso_gap_timer #(.W(G_W)) u_gap_timer (
      .clk      (CLK),
      .rst_n    (ASYNCRESETN),
      .load     (last_bit_c),
      .load_val (G_W'(GAP - 1)),
      .dec      (state_q == ST_GAP),
      .zero_c   (gap_zero_c)
    );
  end else begin : g_no_gap
    assign gap_zero_c = 1'b1;
  end

  // State, bit index and frame counter.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      frames_q <= frames_d;
    end
  end

  // Handshake and next-state decode; ready is held low during reset so LOAD
  // cannot fire into the PISO while the block is being reset.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    frames_d   = frames_q;
    last_bit_c = (state_q == ST_SHIFT) && (idx_q == IDX_LAST);
    ready_c    = ASYNCRESETN && !HALT &&
                 ((state_q == ST_IDLE) || (last_bit_c && B2B));
    load_c     = IN_VALID && ready_c;

    unique case (state_q)
      ST_IDLE: begin
        if (load_c) begin
          state_d = ST_SHIFT;
          idx_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (!last_bit_c) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          frames_d = frames_q + CNT_W'(1);
          idx_d    = '0;
          if (!B2B)        state_d = ST_GAP;
          else if (load_c) state_d = ST_SHIFT;
          else             state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_zero_c) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign IN_READY = ready_c;
  assign LOAD     = load_c;
  assign PI       = IN_DATA;
  assign SI       = FILL;
  assign SO_VALID = (state_q == ST_SHIFT);
  assign SO_FIRST = SO_VALID && (idx_q == '0);
  assign SO_LAST  = last_bit_c;
  assign BUSY     = (state_q != ST_IDLE);
  assign FRAMES   = frames_q;

endmodule

// File: tb/tb_piso_frame_ctrl.sv
// Bench for piso_frame_ctrl: three instances (GAP=0, GAP=3 with FILL=1,
// GAP=0 with a 4-bit counter) share one stimulus stream. Each feeds its own
// PISO register model; a timeline model (accept cycle, frame window, gap
// window) predicts every output each cycle, and literal checks pin the model.
module tb_piso_frame_ctrl;

  localparam int W  = 10;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid;
  logic          halt;
  logic [W-1:0]  in_data;

  logic [NI-1:0] rdy, ld, sov, sof, sol, bsy, si_w;
  logic [W-1:0]  pi0, pi1, pi2;
  logic [W-1:0]  pi_w [NI];
  logic [15:0]   fr0, fr1;
  logic [3:0]    fr2;
  logic [15:0]   fr_w [NI];

  assign pi_w[0] = pi0;
  assign pi_w[1] = pi1;
  assign pi_w[2] = pi2;
  assign fr_w[0] = fr0;
  assign fr_w[1] = fr1;
  assign fr_w[2] = {12'b0, fr2};

  piso_frame_ctrl #(.WIDTH(W), .GAP(0), .FILL(1'b0), .CNT_W(16)) u0 (
    .CLK(clk), .ASYNCRESETN(rst_n), .IN_VALID(in_valid), .IN_DATA(in_data),
    .IN_READY(rdy[0]), .HALT(halt), .LOAD(ld[0]), .PI(pi0), .SI(si_w[0]),
    .SO_VALID(sov[0]), .SO_FIRST(sof[0]), .SO_LAST(sol[0]), .BUSY(bsy[0]),
    .FRAMES(fr0));

  piso_frame_ctrl #(.WIDTH(W), .GAP(3), .FILL(1'b1), .CNT_W(16)) u1 (
    .CLK(clk), .ASYNCRESETN(rst_n), .IN_VALID(in_valid), .IN_DATA(in_data),
    .IN_READY(rdy[1]), .HALT(halt), .LOAD(ld[1]), .PI(pi1), .SI(si_w[1]),
    .SO_VALID(sov[1]), .SO_FIRST(sof[1]), .SO_LAST(sol[1]), .BUSY(bsy[1]),
    .FRAMES(fr1));

  piso_frame_ctrl #(.WIDTH(W), .GAP(0), .FILL(1'b0), .CNT_W(4)) u2 (
    .CLK(clk), .ASYNCRESETN(rst_n), .IN_VALID(in_valid), .IN_DATA(in_data),
    .IN_READY(rdy[2]), .HALT(halt), .LOAD(ld[2]), .PI(pi2), .SI(si_w[2]),
    .SO_VALID(sov[2]), .SO_FIRST(sof[2]), .SO_LAST(sol[2]), .BUSY(bsy[2]),
    .FRAMES(fr2));

  // PISO registers: load PI, otherwise shift left with SI into bit 0.
  logic [W-1:0] piso [NI];
  always_ff @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (ld[i]) piso[i] <= pi_w[i];
      else       piso[i] <= {piso[i][W-2:0], si_w[i]};
    end
  end

  function automatic int gap_of(input int i);
    return (i == 1) ? 3 : 0;
  endfunction
  function automatic int cnt_of(input int i);
    return (i == 2) ? 4 : 16;
  endfunction
  function automatic int fill_of(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  // Timeline model: last accept cycle, its word, completed-frame count.
  longint       cyc_n;
  bit           have [NI];
  longint       acc_t [NI];
  logic [W-1:0] word [NI];
  int           frm [NI];

  // Observations used by the literal checks.
  logic [W-1:0] cap0;
  longint       first0;
  int           run0, maxrun0;
  longint       firsts1 [$];
  logic [NI-1:0] obs_ld;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input int i, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s u%0d cycle %0d: got %0d expected %0d", nm, i, cyc_n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      have[i]  = 1'b0;
      acc_t[i] = 0;
      word[i]  = '0;
      frm[i]   = 0;
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then
  // step past the rising edge.
  task automatic tick();
    longint a;
    int     g;
    bit     in_f, bz, rd, el;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      a    = acc_t[i];
      g    = gap_of(i);
      in_f = have[i] && (cyc_n >= a + 1) && (cyc_n <= a + W);
      bz   = have[i] && (cyc_n >= a + 1) && (cyc_n <= a + W + g);
      rd   = rst_n && !halt && (!bz || (g == 0 && cyc_n == a + W));
      el   = in_valid && rd;
      chk("IN_READY", i, rdy[i], rd);
      chk("LOAD", i, ld[i], el);
      chk("SO_VALID", i, sov[i], in_f);
      chk("SO_FIRST", i, sof[i], in_f && (cyc_n == a + 1));
      chk("SO_LAST", i, sol[i], in_f && (cyc_n == a + W));
      chk("BUSY", i, bsy[i], bz);
      chk("FRAMES", i, fr_w[i], frm[i]);
      chk("PI", i, pi_w[i], in_data);
      chk("SI", i, si_w[i], fill_of(i));
      if (in_f)
        chk("O", i, piso[i][W-1], word[i][W - 1 - int'(cyc_n - a - 1)]);
      if (have[i] && cyc_n == a + W)
        frm[i] = (frm[i] + 1) & ((1 << cnt_of(i)) - 1);
      if (el) begin
        have[i]  = 1'b1;
        acc_t[i] = cyc_n;
        word[i]  = in_data;
      end
    end
    if (sov[0]) begin
      cap0 = {cap0[W-2:0], piso[0][W-1]};
      run0++;
    end else begin
      run0 = 0;
    end
    if (run0 > maxrun0) maxrun0 = run0;
    if (sof[0]) first0 = cyc_n;
    if (sof[1]) firsts1.push_back(cyc_n);
    obs_ld = ld;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  longint t0;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    halt     = 1'b0;
    in_data  = '0;
    cyc_n    = 0;
    cap0     = '0;
    first0   = -1;
    run0     = 0;
    maxrun0  = 0;
    obs_ld   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with IN_VALID high to show LOAD stays low.
    in_valid = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_LOAD", i, ld[i], 0);
      chk("rst_IN_READY", i, rdy[i], 0);
      chk("rst_SO_VALID", i, sov[i], 0);
      chk("rst_BUSY", i, bsy[i], 0);
      chk("rst_FRAMES", i, fr_w[i], 0);
    end
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word 0x2B5.
    cap0 = '0; in_valid = 1'b1; in_data = 10'h2B5; t0 = cyc_n;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      in_data = W'($urandom);
      tick();
    end
    chk("t1_bits", 0, cap0, 10'b1010110101);
    chk("t1_first", 0, first0, t0 + 1);
    chk("t1_frames", 0, fr_w[0], 1);

    // Back-to-back 0x3FF then 0x000 with IN_VALID held.
    run0 = 0; maxrun0 = 0; in_valid = 1'b1; in_data = 10'h3FF;
    tick();
    in_data = 10'h000;
    repeat (10) tick();
    in_valid = 1'b0;
    repeat (15) tick();
    chk("t2_run", 0, maxrun0, 20);
    chk("t2_frames", 0, fr_w[0], 3);

    // Continuous presentation into the GAP=3 instance.
    firsts1.delete();
    in_valid = 1'b1; in_data = 10'h155;
    repeat (30) tick();
    in_valid = 1'b0;
    repeat (16) tick();
    chk("t3_count", 1, firsts1.size(), 3);
    if (firsts1.size() >= 2)
      chk("t3_spacing", 1, firsts1[1] - firsts1[0], 14);

    // HALT raised at frame bit 4, released later.
    in_valid = 1'b1; in_data = 10'h0F0;
    repeat (5) tick();
    halt = 1'b1;
    repeat (10) tick();
    chk("t4_held", 0, obs_ld[0], 0);
    halt = 1'b0;
    tick();
    chk("t4_resume", 0, obs_ld[0], 1);
    in_valid = 1'b0;
    repeat (16) tick();

    // Asynchronous reset in the middle of a frame (bit index 5).
    in_valid = 1'b1; in_data = 10'h1C3;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("arst_SO_VALID", i, sov[i], 0);
      chk("arst_BUSY", i, bsy[i], 0);
      chk("arst_LOAD", i, ld[i], 0);
      chk("arst_FRAMES", i, fr_w[i], 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    cyc_n++;
    cap0 = '0; first0 = -1; in_valid = 1'b1; in_data = 10'h2B5; t0 = cyc_n;
    tick();
    in_valid = 1'b0;
    repeat (12) tick();
    chk("t5_bits", 0, cap0, 10'b1010110101);
    chk("t5_first", 0, first0, t0 + 1);
    chk("t5_frames", 0, fr_w[0], 1);

    // Counter wrap on the 4-bit instance: one frame already counted,
    // fourteen more give 15, the fifteenth wraps to 0.
    in_valid = 1'b1;
    for (int k = 0; k < 141; k++) begin
      in_data = W'(k * 37 + 5);
      tick();
    end
    chk("t6_pre_wrap", 2, fr_w[2], 15);
    in_valid = 1'b0;
    repeat (12) tick();
    chk("t6_wrap", 2, fr_w[2], 0);
    chk("t6_wide", 0, fr_w[0], 16);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
